// File: rtl/des_key_sched_pkg.sv
// Shared DES key-schedule constants: PC-1/PC-2 selection tables, shift schedule,
// controller state encoding and 28-bit rotate helpers.
package des_key_sched_pkg;

   typedef logic [1:0] state_t;

   localparam state_t S_IDLE = 2'd0;
   localparam state_t S_RUN  = 2'd1;
   localparam state_t S_DONE = 2'd2;

   // Entry n is the FIPS 46 key bit number feeding output bit n+1 of C||D.
   localparam logic [6:0] PC1 [0:55] = '{
      7'd57, 7'd49, 7'd41, 7'd33, 7'd25, 7'd17, 7'd9,
      7'd1,  7'd58, 7'd50, 7'd42, 7'd34, 7'd26, 7'd18,
      7'd10, 7'd2,  7'd59, 7'd51, 7'd43, 7'd35, 7'd27,
      7'd19, 7'd11, 7'd3,  7'd60, 7'd52, 7'd44, 7'd36,
      7'd63, 7'd55, 7'd47, 7'd39, 7'd31, 7'd23, 7'd15,
      7'd7,  7'd62, 7'd54, 7'd46, 7'd38, 7'd30, 7'd22,
      7'd14, 7'd6,  7'd61, 7'd53, 7'd45, 7'd37, 7'd29,
      7'd21, 7'd13, 7'd5,  7'd28, 7'd20, 7'd12, 7'd4
   };

   // Entry n is the C||D bit number feeding subkey bit n+1.
   localparam logic [5:0] PC2 [0:47] = '{
      6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,
      6'd3,  6'd28, 6'd15, 6'd6,  6'd21, 6'd10,
      6'd23, 6'd19, 6'd12, 6'd4,  6'd26, 6'd8,
      6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
      6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55,
      6'd30, 6'd40, 6'd51, 6'd45, 6'd33, 6'd48,
      6'd44, 6'd49, 6'd39, 6'd56, 6'd34, 6'd53,
      6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
   };

   localparam logic [1:0] SHIFTS [0:15] = '{
      2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
      2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
   };

   function automatic logic [28:1] rotl28(input logic [28:1] v, input logic [1:0] n);
      return (n == 2'd2) ? {v[26:1], v[28:27]} : {v[27:1], v[28]};
   endfunction

   function automatic logic [28:1] rotr28(input logic [28:1] v, input logic [1:0] n);
      return (n == 2'd2) ? {v[2:1], v[28:3]} : {v[1], v[28:2]};
   endfunction

endpackage

// File: rtl/des_pc2.sv
// Combinational PC-2 selection: 56-bit C||D to 48-bit round subkey.
module des_pc2
   import des_key_sched_pkg::*;
(
   input  logic [56:1] cd,
   output logic [48:1] subkey
);

   for (genvar j = 1; j <= 48; j++) begin : g_sel
      assign subkey[49 - j] = cd[57 - int'(PC2[j - 1])];
   end

endmodule

// File: rtl/des_key_sched.sv
// Iterative DES key scheduler: presents K1..K16 (or K16..K1) one per
// valid/ready handshake from a single rotating C/D register pair.
module des_key_sched
   import des_key_sched_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [64:1] key_in,
   input  logic        start,
   input  logic        decrypt,
   input  logic        abort,
   input  logic        subkey_ready,
   output logic        busy,
   output logic [48:1] subkey,
   output logic        subkey_valid,
   output logic [4:1]  key_idx,
   output logic        done
);

   state_t      state;
   logic [28:1] c;
   logic [28:1] d;
   logic [4:1]  cnt;
   logic        dec;
   logic [56:1] pc1_cd;
   logic [1:0]  step;
   logic        unused_parity;

   for (genvar j = 1; j <= 56; j++) begin : g_pc1
      assign pc1_cd[57 - j] = key_in[65 - int'(PC1[j - 1])];
   end

   assign unused_parity = ^{key_in[57], key_in[49], key_in[41], key_in[33],
                            key_in[25], key_in[17], key_in[9],  key_in[1]};

   // Encrypt steps toward the next key; decrypt undoes the shift of the key just shown.
   assign step = dec ? SHIFTS[4'd15 - cnt] : SHIFTS[cnt + 4'd1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         c     <= '0;
         d     <= '0;
         cnt   <= '0;
         dec   <= 1'b0;
      end else if (abort) begin
         state <= S_IDLE;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  dec   <= decrypt;
                  cnt   <= '0;
                  state <= S_RUN;
                  if (decrypt) begin
                     c <= pc1_cd[56:29];
                     d <= pc1_cd[28:1];
                  end else begin
                     c <= rotl28(pc1_cd[56:29], SHIFTS[0]);
                     d <= rotl28(pc1_cd[28:1], SHIFTS[0]);
                  end
               end
            end
            S_RUN: begin
               if (subkey_ready) begin
                  // The 16th step wraps C/D back to their post-load value.
                  cnt <= cnt + 4'd1;
                  c   <= dec ? rotr28(c, step) : rotl28(c, step);
                  d   <= dec ? rotr28(d, step) : rotl28(d, step);
                  if (cnt == 4'd15) begin
                     state <= S_DONE;
                  end
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   assign busy         = (state != S_IDLE);
   assign subkey_valid = (state == S_RUN);
   assign done         = (state == S_DONE);
   assign key_idx      = dec ? (4'd15 - cnt) : cnt;

   des_pc2 u_pc2 (
      .cd     ({c, d}),
      .subkey (subkey)
   );

endmodule

// File: tb/tb_des_key_sched.sv
// Bench for des_key_sched: textbook DES key-schedule model plus directed runs.
module tb_des_key_sched;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [64:1] key_in = '0;
   logic        start = 1'b0;
   logic        decrypt = 1'b0;
   logic        abort = 1'b0;
   logic        subkey_ready = 1'b1;
   logic        busy;
   logic [48:1] subkey;
   logic        subkey_valid;
   logic [4:1]  key_idx;
   logic        done;

   int n_checks = 0;
   int n_fail = 0;

   localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;
   localparam logic [63:0] KEY_B = 64'h123456789ABCDEF0;
   localparam logic [47:0] K1_A  = 48'h1B02EFFC7072;
   localparam logic [47:0] K2_A  = 48'h79AED9DBC9E5;
   localparam logic [47:0] K16_A = 48'hCB3D8B0E17F5;

   des_key_sched dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .key_in       (key_in),
      .start        (start),
      .decrypt      (decrypt),
      .abort        (abort),
      .subkey_ready (subkey_ready),
      .busy         (busy),
      .subkey       (subkey),
      .subkey_valid (subkey_valid),
      .key_idx      (key_idx),
      .done         (done)
   );

   always #5 clk = ~clk;

   int pc1_t [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27,
                      19,11,3,60,52,44,36, 63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                      14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
   int pc2_t [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
                      41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
   int sh_t [16]  = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

   // Subkey K_r computed from scratch: PC-1, cumulative left rotation, PC-2.
   function automatic logic [47:0] sched_key(input logic [63:0] key, input int r);
      int cd [56];
      int cdr [56];
      int tot;
      logic [47:0] res;
      for (int i = 0; i < 56; i++) cd[i] = int'(key[64 - pc1_t[i]]);
      tot = 0;
      for (int k = 0; k < r; k++) tot += sh_t[k];
      for (int i = 0; i < 28; i++) begin
         cdr[i]      = cd[(i + tot) % 28];
         cdr[28 + i] = cd[28 + ((i + tot) % 28)];
      end
      for (int j = 0; j < 48; j++) res[47 - j] = cdr[pc2_t[j] - 1][0];
      return res;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   // Behavioural reference: position within the schedule.
   int          m_state = 0;
   int          m_n = 0;
   logic        m_dec = 1'b0;
   logic [63:0] m_key = '0;
   logic        m_clr = 1'b1;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_state <= 0;
         m_n     <= 0;
         m_dec   <= 1'b0;
         m_clr   <= 1'b1;
      end else if (abort) begin
         m_state <= 0;
      end else if (m_state == 0) begin
         if (start) begin
            m_state <= 1;
            m_n     <= 0;
            m_dec   <= decrypt;
            m_key   <= key_in;
            m_clr   <= 1'b0;
         end
      end else if (m_state == 1) begin
         if (subkey_ready) begin
            m_n <= m_n + 1;
            if (m_n == 15) m_state <= 2;
         end
      end else begin
         m_state <= 0;
      end
   end

   function automatic int exp_index();
      return m_dec ? (15 - m_n) : m_n;
   endfunction

   logic [47:0] prev_key = '0;
   logic [3:0]  prev_idx = '0;
   logic        prev_valid = 1'b0;

   always @(negedge clk) begin
      check("busy", 64'(busy), 64'(m_state != 0));
      check("subkey_valid", 64'(subkey_valid), 64'(m_state == 1));
      check("done", 64'(done), 64'(m_state == 2));
      if (m_state == 1) begin
         check("key_idx", 64'(key_idx), 64'(exp_index()));
         check("subkey", 64'(subkey), 64'(sched_key(m_key, exp_index() + 1)));
      end else if (m_state == 0 && m_clr) begin
         check("key_idx_cleared", 64'(key_idx), 64'd0);
         check("subkey_cleared", 64'(subkey), 64'd0);
      end
      if (rst_n && prev_valid && !subkey_ready && !abort) begin
         check("stall_valid", 64'(subkey_valid), 64'd1);
         check("stall_subkey", 64'(subkey), 64'(prev_key));
         check("stall_idx", 64'(key_idx), 64'(prev_idx));
      end
      prev_valid <= rst_n && subkey_valid;
      prev_key   <= subkey;
      prev_idx   <= key_idx;
   end

   logic [47:0] acc_key [$];
   int          acc_idx [$];
   int          cyc = 0;
   int          last_acc_cyc = 0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rst_n && subkey_valid && subkey_ready && !abort) begin
         acc_key.push_back(subkey);
         acc_idx.push_back(int'(key_idx));
         last_acc_cyc <= cyc;
      end
   end

   logic stall_en = 1'b0;
   int   stall_left = 0;

   initial forever begin
      @(negedge clk);
      #1;
      if (!stall_en) begin
         subkey_ready = 1'b1;
      end else if (stall_left > 0) begin
         subkey_ready = 1'b0;
         stall_left--;
      end else begin
         subkey_ready = 1'b1;
         stall_left = int'($urandom_range(0, 5));
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic start_sched(input logic [63:0] k, input logic dir);
      tick();
      acc_key.delete();
      acc_idx.delete();
      key_in  = k;
      decrypt = dir;
      start   = 1'b1;
      tick();
      start = 1'b0;
      check("start_latency_valid", 64'(subkey_valid), 64'd1);
   endtask

   task automatic run_to_done(input bit junk);
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < 400; k++) begin
         if (done) begin
            seen = 1'b1;
            break;
         end
         if (junk && k == 3) begin
            start   = 1'b1;
            key_in  = 64'hFEDCBA9876543210;
            decrypt = ~decrypt;
         end
         if (junk && k == 4) begin
            start   = 1'b0;
            decrypt = ~decrypt;
         end
         tick();
      end
      check("done_seen", 64'(seen), 64'd1);
      if (seen) check("done_latency", 64'(cyc), 64'(last_acc_cyc + 1));
      check("accept_count", 64'(acc_key.size()), 64'd16);
   endtask

   task automatic wait_idx7();
      bit found;
      found = 1'b0;
      for (int k = 0; k < 40; k++) begin
         if (subkey_valid && key_idx == 4'd7) begin
            found = 1'b1;
            break;
         end
         tick();
      end
      check("reach_idx7", 64'(found), 64'd1);
   endtask

   logic [47:0] enc_a [16];
   int          done_pulses;

   initial begin
      check("model_K1", 64'(sched_key(KEY_A, 1)), 64'(K1_A));
      check("model_K2", 64'(sched_key(KEY_A, 2)), 64'(K2_A));
      check("model_K16", 64'(sched_key(KEY_A, 16)), 64'(K16_A));

      #1 rst_n = 1'b0;
      repeat (3) tick();
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_valid", 64'(subkey_valid), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_key_idx", 64'(key_idx), 64'd0);
      check("rst_subkey", 64'(subkey), 64'd0);

      // Encrypt, start presented on the first edge after reset release.
      acc_key.delete();
      acc_idx.delete();
      rst_n   = 1'b1;
      key_in  = KEY_A;
      decrypt = 1'b0;
      start   = 1'b1;
      tick();
      start = 1'b0;
      check("enc_first_valid", 64'(subkey_valid), 64'd1);
      check("enc_first_idx", 64'(key_idx), 64'd0);
      check("enc_first_key", 64'(subkey), 64'(K1_A));
      run_to_done(1'b0);
      check("enc_last_key", 64'(acc_key[15]), 64'(K16_A));
      check("enc_last_idx", 64'(acc_idx[15]), 64'd15);
      for (int i = 0; i < 16; i++) enc_a[i] = acc_key[i];
      start = 1'b1;
      tick();
      start = 1'b0;
      check("start_in_done_ignored", 64'(busy), 64'd0);

      // Decrypt: exact reverse order.
      start_sched(KEY_A, 1'b1);
      check("dec_first_idx", 64'(key_idx), 64'd15);
      check("dec_first_key", 64'(subkey), 64'(K16_A));
      run_to_done(1'b0);
      check("dec_last_key", 64'(acc_key[15]), 64'(K1_A));
      check("dec_last_idx", 64'(acc_idx[15]), 64'd0);
      for (int i = 0; i < 16; i++) begin
         check("dec_reverse_key", 64'(acc_key[i]), 64'(enc_a[15 - i]));
         check("dec_reverse_idx", 64'(acc_idx[i]), 64'(15 - i));
      end

      // Parity-only key difference with random ready stalls.
      stall_en = 1'b1;
      start_sched(KEY_B, 1'b0);
      run_to_done(1'b0);
      stall_en = 1'b0;
      for (int i = 0; i < 16; i++) begin
         check("parity_stall_key", 64'(acc_key[i]), 64'(enc_a[i]));
         check("parity_stall_idx", 64'(acc_idx[i]), 64'(i));
      end

      // Start pulsed mid-run must not disturb the sequence.
      repeat (2) tick();
      start_sched(KEY_A, 1'b0);
      run_to_done(1'b1);
      for (int i = 0; i < 16; i++) check("start_in_run_key", 64'(acc_key[i]), 64'(enc_a[i]));

      // Abort at key_idx 7.
      repeat (2) tick();
      start_sched(KEY_A, 1'b0);
      wait_idx7();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_valid", 64'(subkey_valid), 64'd0);
      check("abort_busy", 64'(busy), 64'd0);
      done_pulses = 0;
      for (int k = 0; k < 20; k++) begin
         if (done) done_pulses++;
         tick();
      end
      check("abort_no_done", 64'(done_pulses), 64'd0);

      // Reset pulse at key_idx 7, then a fresh schedule.
      start_sched(KEY_A, 1'b0);
      wait_idx7();
      rst_n = 1'b0;
      #1;
      check("midrst_busy", 64'(busy), 64'd0);
      check("midrst_valid", 64'(subkey_valid), 64'd0);
      check("midrst_done", 64'(done), 64'd0);
      check("midrst_idx", 64'(key_idx), 64'd0);
      check("midrst_subkey", 64'(subkey), 64'd0);
      tick();
      rst_n = 1'b1;
      done_pulses = 0;
      for (int k = 0; k < 5; k++) begin
         if (done) done_pulses++;
         tick();
      end
      check("midrst_no_done", 64'(done_pulses), 64'd0);
      start_sched(KEY_A, 1'b0);
      check("after_rst_idx", 64'(key_idx), 64'd0);
      check("after_rst_key", 64'(subkey), 64'(K1_A));
      run_to_done(1'b0);

      repeat (2) tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/des_key_sched.md
DES_KEY_SCHED -- requirements
Module: des_key_sched

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed by DES.
REQ-002 clk  input  1  single clock; every flop SHALL be updated on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 key_in  input  [64:1]  DES key in FIPS 46 bit order; parity bits 8,16,...,64 SHALL be ignored.
REQ-005 start  input  1  request to begin a schedule; sampled only in IDLE.
REQ-006 decrypt  input  1  direction, sampled with start: 0 = K1..K16 order, 1 = K16..K1 order.
REQ-007 abort  input  1  synchronous cancel; forces IDLE on the next edge.
REQ-008 busy  output  1  high in every state except IDLE.
REQ-009 subkey  output  [48:1]  current 48-bit round subkey, PC-2 of the current C and D registers.
REQ-010 subkey_valid  output  1  subkey is presented; held until accepted.
REQ-011 subkey_ready  input  1  consumer accepts subkey on a cycle where subkey_valid and subkey_ready are both 1.
REQ-012 key_idx  output  [4:1]  encryption-order index of the presented subkey, 0 = K1 to 15 = K16.
REQ-013 done  output  1  one-cycle pulse on the edge after the 16th subkey is accepted.

Function
REQ-014 States SHALL be IDLE, RUN and DONE.
REQ-015 IDLE with start=1 SHALL load C,D = PC-1(key_in), latch decrypt, clear the round counter, and enter RUN.
REQ-016 Encrypt mode SHALL rotate C and D left as they are loaded, with the shift of round 1 applied at load.
REQ-017 Encrypt mode SHALL present K1 in the first RUN cycle.
REQ-018 Decrypt mode SHALL load C,D unrotated, so the first RUN cycle presents K16 = PC-2(C0,D0).
REQ-019 Each handshake SHALL advance the counter and rotate C and D by the schedule amount for the next key.
REQ-020 The encrypt shift schedule for rounds 1..16 SHALL be 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 (left rotation).
REQ-021 Each decrypt step SHALL rotate right by the amount that produced the key just presented.
REQ-022 The decrypt rotations SHALL therefore be 1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 after K16 has been presented.
REQ-023 After 16 accepts, C and D SHALL equal their post-load values (28-bit wrap, net rotation 28).
REQ-024 key_idx SHALL count 0..15 in encrypt mode and 15..0 in decrypt mode.
REQ-025 Latency SHALL be one cycle from start sampled in IDLE to subkey_valid=1.
REQ-026 With subkey_ready held at 1, one subkey SHALL be delivered per cycle, 16 cycles per schedule.
REQ-027 While subkey_valid=1 and subkey_ready=0, subkey and key_idx SHALL hold stable.
REQ-028 Acceptance of the 16th subkey SHALL enter DONE; DONE SHALL assert done and return to IDLE after one cycle.
REQ-029 start while busy SHALL be ignored, with no effect on the schedule in progress.
REQ-030 start in DONE SHALL be ignored; a new schedule SHALL start no sooner than the next IDLE cycle.
REQ-031 abort SHALL take priority over the handshake and over done.
REQ-032 abort SHALL drop subkey_valid, return to IDLE, and SHALL NOT pulse done.
REQ-033 subkey_valid SHALL be 0 in IDLE and DONE.

Reset
REQ-034 rst_n=0 SHALL immediately force IDLE and clear C, D, counter and the latched direction.
REQ-035 Reset SHALL drive busy=0, subkey_valid=0, done=0, key_idx=0 and subkey=0.
REQ-036 Reset asserted mid-schedule SHALL abandon it, and no done pulse SHALL follow.
REQ-037 Release of rst_n SHALL be treated as a synchronous event; the first start is sampled on the first edge after release.

Structure
REQ-038 A shared DES package SHALL hold the PC-1 and PC-2 permutation tables and the 16-entry shift-schedule constant.
REQ-039 The package SHALL also hold the state-encoding typedef.
REQ-040 The combinational 56-to-48 selection SHALL be a sub-module named des_pc2.
REQ-041 des_pc2 SHALL be reused by any future unrolled key path.

Verification
REQ-042 Key 0x133457799BBCDFF1, encrypt, ready=1 -> first subkey 0x1B02EFFC7072 with key_idx=0.
REQ-043 The same run -> 16th subkey 0xCB3D8B0E17F5 with key_idx=15, and done one cycle later.
REQ-044 Same key, decrypt -> first subkey 0xCB3D8B0E17F5 (key_idx=15), last 0x1B02EFFC7072 (key_idx=0); full sequence is the exact reverse of the encrypt run.
REQ-045 Random ready stalls of 0-5 cycles -> subkey and key_idx stable while stalled, no key lost or duplicated, and exactly 16 accepts.
REQ-046 Keys differing only in parity bits (0x133457799BBCDFF1 vs 0x123456789ABCDEF0 pattern pair) -> identical subkey sequences.
REQ-047 abort at key_idx=7 -> subkey_valid=0 on the next cycle, busy=0, no done pulse.
REQ-048 rst_n pulse at key_idx=7 -> outputs zero immediately; a following start produces K1 again.
REQ-049 start pulsed during RUN -> no effect on the sequence in progress.
